titan_boot_loader: RTL and testbench

Boot sequencer for the Titan 16-bit processor: after board `reset` it holds the core in reset, copies a program image from a synchronous ROM into Titan's instruction/data memory, then releases the core. It replaces the simulation-only reset stimulus with synthesizable logic that drives the core's `reset` input and the memory write port. It sits between the top-level board logic, the boot ROM, and the `Titan` core/memory.

---
 rtl/titan_boot_loader.sv | 115 +++++++++++
 tb/tb_titan_boot_loader.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/titan_boot_loader.sv
// titan_boot_loader: after reset, holds the Titan core in reset, copies a boot
// ROM image into its memory, then releases the core. A restart request in RUN
// reloads the image and re-runs it.
module titan_boot_loader #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned LOAD_WORDS = 1024,
  parameter int unsigned RESET_HOLD = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_reset,
  output logic              load_done
);

  localparam int unsigned       CNT_W     = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LOAD_WORDS - 1);
  localparam logic [CNT_W-1:0]  LAST_HOLD = CNT_W'(RESET_HOLD - 1);

  typedef enum logic [1:0] {
    st_hold  = 2'd0,
    st_load  = 2'd1,
    st_drain = 2'd2,
    st_run   = 2'd3
  } state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  hold_cnt, hold_cnt_d;
  logic [ADDR_W-1:0] rom_addr_d;
  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic              core_reset_d;
  logic              load_done_d;

  // ROM data arrives exactly in the cycle its word is written, so it passes straight through.
  assign mem_wdata = rom_data;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= st_hold;
      hold_cnt   <= '0;
      rom_addr   <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      core_reset <= 1'b1;
      load_done  <= 1'b0;
    end else begin
      state      <= state_d;
      hold_cnt   <= hold_cnt_d;
      rom_addr   <= rom_addr_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      core_reset <= core_reset_d;
      load_done  <= load_done_d;
    end
  end

  // Next state and next output values; the load ends on a compare, never on address wrap.
  always_comb begin
    state_d      = state;
    hold_cnt_d   = hold_cnt;
    rom_addr_d   = rom_addr;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr;
    core_reset_d = 1'b1;
    load_done_d  = 1'b0;

    unique case (state)
      st_hold: begin
        if (hold_cnt == LAST_HOLD) begin
          state_d    = st_load;
          rom_addr_d = '0;
        end else begin
          hold_cnt_d = hold_cnt + CNT_W'(1);
        end
      end
      st_load: begin
        // Word at the current address is written in the following cycle.
        mem_we_d   = 1'b1;
        mem_addr_d = rom_addr;
        if (rom_addr == LAST_ADDR) begin
          state_d = st_drain;
        end else begin
          rom_addr_d = rom_addr + ADDR_W'(1);
        end
      end
      st_drain: begin
        state_d      = st_run;
        core_reset_d = 1'b0;
        load_done_d  = 1'b1;
      end
      st_run: begin
        if (restart) begin
          state_d    = st_hold;
          hold_cnt_d = '0;
          rom_addr_d = '0;
        end else begin
          core_reset_d = 1'b0;
          load_done_d  = 1'b1;
        end
      end
      default: begin
        state_d = st_hold;
      end
    endcase
  end

endmodule

// File: tb/tb_titan_boot_loader.sv
// tb_titan_boot_loader: two loaders (8-word full-range image and 1-word image)
// under directed and random reset/restart traffic, checked against a timing
// model of the boot sequence via a write scoreboard.
module tb_titan_boot_loader;

  localparam int RH  = 4;
  localparam int BIG = 1 << 30;

  typedef struct {
    int          inst;
    int          cyc;
    logic [2:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic clk;
  logic reset;
  logic restart;

  logic [2:0]  rom_addr   [2];
  logic [15:0] rom_data   [2];
  logic        mem_we     [2];
  logic [2:0]  mem_addr   [2];
  logic [15:0] mem_wdata  [2];
  logic        core_reset [2];
  logic        load_done  [2];
  logic [15:0] tbmem      [2][8];

  int  cyc = 0;
  logic rst_seen = 1'b1;
  int  bs [2];
  wr_t q [$];
  int  n_chk = 0;
  int  n_fail = 0;
  bit  do_final = 0;
  bit  final_done = 0;

  titan_boot_loader #(.ADDR_W(3), .DATA_W(16), .LOAD_WORDS(8), .RESET_HOLD(RH)) u_full (
    .clk(clk), .reset(reset), .restart(restart),
    .rom_addr(rom_addr[0]), .rom_data(rom_data[0]),
    .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .core_reset(core_reset[0]), .load_done(load_done[0])
  );

  titan_boot_loader #(.ADDR_W(3), .DATA_W(16), .LOAD_WORDS(1), .RESET_HOLD(RH)) u_one (
    .clk(clk), .reset(reset), .restart(restart),
    .rom_addr(rom_addr[1]), .rom_data(rom_data[1]),
    .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .core_reset(core_reset[1]), .load_done(load_done[1])
  );

  function automatic int lw(int i);
    return (i == 0) ? 8 : 1;
  endfunction

  // Core runs from cycle (boot start + hold + load + drain) until the next restart/reset.
  function automatic bit exp_run(int i, int c);
    return c >= bs[i] + RH + lw(i) + 1;
  endfunction

  function automatic void chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", nm, i, cyc, act, exp);
    end
  endfunction

  // Word k of a boot starting at cycle b is written at cycle b+RH+1+k.
  function automatic void push_boot(int i, int b);
    for (int k = 0; k < lw(i); k++)
      q.push_back('{i, b + RH + 1 + k, 3'(k), 16'hA000 + 16'(k)});
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter, reset-sample history, ROM with 1-cycle latency, memory image.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
    for (int i = 0; i < 2; i++) begin
      rom_data[i] <= 16'hA000 + 16'(rom_addr[i]);
      if (mem_we[i]) tbmem[i][mem_addr[i]] <= mem_wdata[i];
    end
  end

  // Applies inputs for the current cycle and updates the model.
  task automatic step(input bit rst, input bit rs);
    @(negedge clk);
    #1;
    if (rst) begin
      for (int j = q.size() - 1; j >= 0; j--)
        if (q[j].cyc > cyc) q.delete(j);
      bs = '{BIG, BIG};
    end else if (reset) begin
      for (int i = 0; i < 2; i++) begin
        bs[i] = cyc;
        push_boot(i, cyc);
      end
    end else if (rs) begin
      for (int i = 0; i < 2; i++)
        if (exp_run(i, cyc)) begin
          bs[i] = cyc + 1;
          push_boot(i, cyc + 1);
        end
    end
    reset   = rst;
    restart = rs;
  endtask

  // Monitor: pops expected writes and checks control outputs every cycle.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        int idx;
        int rel;
        idx = -1;
        foreach (q[j]) if (q[j].inst == i && q[j].cyc == cyc) idx = j;
        if (idx >= 0) begin
          chk("mem_we", i, 32'(mem_we[i]), 32'd1);
          chk("mem_addr", i, 32'(mem_addr[i]), 32'(q[idx].addr));
          chk("mem_wdata", i, 32'(mem_wdata[i]), 32'(q[idx].data));
          q.delete(idx);
        end else begin
          chk("spurious_we", i, 32'(mem_we[i]), 32'd0);
        end
        chk("core_reset", i, 32'(core_reset[i]), 32'(!exp_run(i, cyc)));
        chk("load_done", i, 32'(load_done[i]), 32'(exp_run(i, cyc)));
        if (rst_seen) begin
          chk("rst_rom_addr", i, 32'(rom_addr[i]), 32'd0);
          chk("rst_mem_addr", i, 32'(mem_addr[i]), 32'd0);
        end else begin
          rel = cyc - bs[i] - RH;
          if (rel >= 0 && rel < lw(i))
            chk("load_rom_addr", i, 32'(rom_addr[i]), 32'(rel));
        end
      end
      if (do_final && !final_done) begin
        for (int i = 0; i < 2; i++)
          for (int k = 0; k < lw(i); k++)
            chk("final_mem", i, 32'(tbmem[i][k]), 32'(16'hA000 + 16'(k)));
        final_done = 1;
      end
    end
  end

  // Stimulus: directed boot, mid-load reset, restarts, idle, then random traffic.
  initial begin
    int b;
    bit rst;
    bit rs;
    int r;
    reset   = 1'b1;
    restart = 1'b0;
    bs      = '{BIG, BIG};

    step(1, 0);
    step(1, 0);
    step(0, 0);
    b = cyc;

    while (cyc < b + 6) step(0, 0);
    step(1, 0);
    step(0, 0);
    b = cyc;

    while (cyc < b + 19) step(0, 0);
    step(0, 1);
    b = cyc + 1;
    while (cyc < b + 5) step(0, 0);
    step(0, 1);
    while (cyc < b + 13 + 100) step(0, 0);

    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 63));
      if (reset) rst = ($urandom_range(0, 2) == 0);
      else       rst = (r == 0);
      rs = (r >= 56);
      step(rst, rs);
    end
    for (int n = 0; n < 30; n++) step(0, 0);

    do_final = 1;
    for (int n = 0; n < 5 && !final_done; n++) @(negedge clk);
    if (!final_done) begin
      $display("FAIL final_check: monitor did not complete");
      $fatal(1, "monitor stalled");
    end
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
